axi_read_master: RTL and testbench
==================================

// Module: axi_read_master
//
// PURPOSE
// AXI4 read initiator. Accepts a (byte address, word count) command, splits it into
// INCR bursts (bounded by BURST_MAX and 4KB boundaries) and issues them on the AR channel.
// Returns read data as a valid/ready word stream with a last flag.
// Used by boot/DMA-style copy engines to pull data from AXI responders (ROM, SDRAM controller).
// Read-only initiator; write channels are tied inactive.
//
// PARAMETERS
// BURST_MAX   8    max beats per AXI burst (1..256); arlen = beats-1
//
// PORTS
// clk          in   1    clock
// reset        in   1    asynchronous, active-high reset
// cmd_valid    in   1    command request
// cmd_ready    out  1    command accepted when valid&ready (high only in IDLE)
// cmd_addr     in   32   start byte address; bits [1:0] ignored (forced 0)
// cmd_words    in   16   number of 32-bit words to read; 0 = no-op
// data_valid   out  1    output word valid
// data_ready   in   1    consumer accepts output word
// data         out  32   read word, in ascending address order
// data_last    out  1    marks final word of the command
// done         out  1    one-cycle pulse when last beat of command received (or no-op)
// axi_bus      -    -    axi4_interface.master
//
// BEHAVIOUR
// Reset: all state to IDLE. Outputs: cmd_ready=0 (1 from first cycle after reset, in IDLE),
//   m_arvalid=0, m_rready=0, data_valid=0, data_last=0, done=0.
// Tie-offs: m_awvalid=0, m_wvalid=0, m_bready=1.
// State machine:
//   IDLE: cmd_ready=1. On cmd_valid, latch addr={cmd_addr[31:2],2'b0}, remaining=cmd_words.
//         If cmd_words==0, pulse done next cycle and stay in IDLE. Otherwise go to ADDR.
//   ADDR: m_arvalid=1, m_araddr=addr, m_arlen=len-1.
//         len=min(remaining, BURST_MAX, 1024-addr[11:2]).
//         len is computed once on entry and registered.
//         araddr/arlen are held stable until s_arready. On handshake go to DATA with beat_cnt=len.
//   DATA: m_rready=(!data_valid || data_ready).
//         On each s_rvalid&m_rready: data<=s_rdata, data_valid<=1, beat_cnt--, remaining--.
//         data_last<=1 iff remaining==1 at that beat.
//         After last beat of burst (beat_cnt==1): addr+=len*4 (32-bit, modular).
//         Then go to ADDR if remaining>1, else go to IDLE with done pulse.
// Output buffer: one register stage. data_valid clears when data_ready and no new beat is accepted.
//   If a beat is accepted while data_ready=1, the register reloads with no bubble.
// Throughput: 1 word/clk in steady state. The AR for the next burst is issued 1 cycle after the previous last beat.
// A new command may be accepted while the final word still waits in the output buffer.
// Backpressure: data_ready low stalls m_rready; no data lost or reordered.
// Beat counting is authoritative; s_rlast is not used.
// Reset mid-burst: returns to IDLE immediately; the outstanding burst is abandoned.
//   The responder must be reset simultaneously.
// cmd_words up to 65535 supported; address wrap past 0xFFFFFFFC is modular and not flagged.
//
// STRUCTURE
// defines package: AXI_BOUNDARY_WORDS=1024 (4KB/4); typedef axi_read_state_t {IDLE, ADDR, DATA}.
// Single module. Burst-length computation is a local function, not a sub-module.
// The output stage is small enough to inline.
//
// TESTING
// 1. cmd addr=0x1000, words=4 -> one AR (0x1000, arlen=3); 4 words in order;
//    data_last on 4th; done 1 pulse.
// 2. addr=0x0, words=20, BURST_MAX=8 -> ARs (0x0,7), (0x20,7), (0x40,3);
//    20 words; data_last only on 20th.
// 3. addr=0xFF8, words=4 -> ARs (0xFF8,1), (0x1000,1); no burst crosses 4KB.
// 4. data_ready low 5 cycles mid-burst -> m_rready low those cycles; all words delivered once, in order.
// 5. words=0 -> no m_arvalid ever; done pulse 1 cycle after accept; cmd_ready stays high.
// 6. s_arready held low 10 cycles -> araddr/arlen stable.
//    Then reset asserted in DATA -> arvalid/rready/data_valid=0 at once; next command runs normally.

Source files
------------

// File: rtl/axi_read_master_pkg.sv
// axi_read_master_pkg: shared constants and state type for the AXI read initiator
package axi_read_master_pkg;
    localparam int AXI_BOUNDARY_WORDS = 1024;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} axi_read_state_t;
endpackage

// File: rtl/axi4_interface.sv
// axi4_interface: AXI4 signal bundle (read channels plus write-channel handshakes to tie off)
//   master: drives AR and R-ready, observes AR-ready and R data/valid
//   slave : mirror view for responders
interface axi4_interface;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        m_rready;
    logic        m_awvalid;
    logic        m_wvalid;
    logic        m_bready;
    modport master(
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_awvalid, m_wvalid, m_bready,
        input  s_arready, s_rdata, s_rvalid
    );
    modport slave(
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_awvalid, m_wvalid, m_bready,
        output s_arready, s_rdata, s_rvalid
    );
endinterface

// File: rtl/axi_read_master.sv
// axi_read_master: splits a (byte address, word count) command into 4KB-safe INCR read bursts
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_addr byte address, cmd_words count (0 = no-op)
//   data_valid/ready  output word stream; data word, data_last on final word of a command
//   done              one-cycle pulse when a command completes
//   axi_bus           AXI4 master port (read only; write channels tied inactive)
module axi_read_master
    import axi_read_master_pkg::*;
#(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_words,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [31:0] data,
    output logic        data_last,
    output logic        done,
    axi4_interface.master axi_bus
);
    axi_read_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  beat_q, beat_d;
    logic [31:0] data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        data_last_q, data_last_d;
    logic        done_q, done_d;
    logic        rready, beat;

    // min(remaining, BURST_MAX, words left before the next 4KB boundary)
    function automatic logic [8:0] burst_len(input logic [9:0] word_in_page, input logic [15:0] r);
        logic [16:0] b, m;
        b = 17'(AXI_BOUNDARY_WORDS) - 17'(word_in_page);
        m = (17'(r) < b) ? 17'(r) : b;
        m = (m < 17'(BURST_MAX)) ? m : 17'(BURST_MAX);
        return 9'(m);
    endfunction

    // Accept a new R beat only when the output register is empty or draining this cycle
    assign rready = (state_q == DATA) && (!data_valid_q || data_ready);
    assign beat   = rready && axi_bus.s_rvalid;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        len_d        = len_q;
        beat_d       = beat_q;
        data_d       = data_q;
        data_valid_d = data_ready ? 1'b0 : data_valid_q;
        data_last_d  = data_ready ? 1'b0 : data_last_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr & ~32'h3;
                rem_d   = cmd_words;
                done_d  = (cmd_words == 16'd0);
                state_d = (cmd_words == 16'd0) ? IDLE : ADDR;
            end
            ADDR: if (axi_bus.s_arready) begin
                state_d = DATA;
                beat_d  = len_q;
            end
            DATA: if (beat) begin
                data_d       = axi_bus.s_rdata;
                data_valid_d = 1'b1;
                data_last_d  = (rem_q == 16'd1);
                beat_d       = beat_q - 9'd1;
                rem_d        = rem_q - 16'd1;
                if (beat_q == 9'd1) begin
                    addr_d  = addr_q + 32'({len_q, 2'b00});
                    state_d = (rem_q > 16'd1) ? ADDR : IDLE;
                    done_d  = (rem_q == 16'd1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Burst length is fixed on entry to ADDR so araddr/arlen stay stable while waiting
        if (state_d == ADDR && state_q != ADDR)
            len_d = burst_len(addr_d[11:2], rem_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready          = (state_q == IDLE) && !reset;
    assign data_valid         = data_valid_q;
    assign data               = data_q;
    assign data_last          = data_last_q;
    assign done               = done_q;
    assign axi_bus.m_arvalid  = (state_q == ADDR);
    assign axi_bus.m_araddr   = addr_q;
    assign axi_bus.m_arlen    = 8'(len_q - 9'd1);
    assign axi_bus.m_arsize   = 3'd2;
    assign axi_bus.m_arburst  = 2'b01;
    assign axi_bus.m_rready   = rready;
    assign axi_bus.m_awvalid  = 1'b0;
    assign axi_bus.m_wvalid   = 1'b0;
    assign axi_bus.m_bready   = 1'b1;
endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: randomized scoreboard bench with a behavioural AXI responder
module tb_axi_read_master;
    localparam int BMAX = 8;

    typedef struct {logic [31:0] d; logic l;} word_t;
    typedef struct {logic [31:0] a; logic [7:0] l;} ar_t;
    typedef struct {logic [31:0] a; int len;} burst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_words;
    logic        data_valid, data_ready, data_last, done;
    logic [31:0] data;

    axi4_interface axi();

    axi_read_master #(.BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .data_valid(data_valid), .data_ready(data_ready), .data(data), .data_last(data_last),
        .done(done), .axi_bus(axi)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dr_low = 0;
    int ar_block = 0;

    word_t exp_q[$];
    ar_t   exp_ar[$];
    int    exp_done[$];
    int    acc_cyc[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred that the model did not expect at %0t", nm, $time);
    endtask

    // Reference model: expected AR sequence and word stream for one command
    task automatic model_cmd(input logic [31:0] addr, input int words);
        logic [31:0] a;
        int rem, len, page_left;
        a = addr & ~32'h3;
        for (int i = 0; i < words; i++)
            exp_q.push_back('{word_at(a + 32'(i * 4)), i == words - 1});
        rem = words;
        while (rem > 0) begin
            page_left = (4096 - int'(a % 4096)) / 4;
            len = rem < BMAX ? rem : BMAX;
            len = len < page_left ? len : page_left;
            exp_ar.push_back('{a, 8'(len - 1)});
            a = a + 32'(len * 4);
            rem -= len;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic ar_wait;
        logic [31:0] pa;
        logic [7:0] pl;
        word_t e;
        ar_t r;
        int n, c;
        ar_wait = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                ar_wait = 1'b0;
                continue;
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) bad("data_extra");
                else begin
                    e = exp_q.pop_front();
                    chk("data", data, e.d);
                    chk("data_last", 32'(data_last), 32'(e.l));
                end
            end
            if (data_valid && !data_ready) chk("rready_stall", 32'(axi.m_rready), 32'd0);
            if (ar_wait) begin
                chk("arvalid_hold", 32'(axi.m_arvalid), 32'd1);
                chk("araddr_hold", axi.m_araddr, pa);
                chk("arlen_hold", 32'(axi.m_arlen), 32'(pl));
            end
            if (axi.m_arvalid && axi.s_arready) begin
                if (exp_ar.size() == 0) bad("ar_extra");
                else begin
                    r = exp_ar.pop_front();
                    chk("araddr", axi.m_araddr, r.a);
                    chk("arlen", 32'(axi.m_arlen), 32'(r.l));
                    chk("arsize_burst", {27'd0, axi.m_arsize, axi.m_arburst}, {27'd0, 3'd2, 2'b01});
                end
            end
            ar_wait = axi.m_arvalid && !axi.s_arready;
            pa = axi.m_araddr;
            pl = axi.m_arlen;
            if (done) begin
                if (exp_done.size() == 0) bad("done_extra");
                else begin
                    n = exp_done.pop_front();
                    c = acc_cyc.pop_front();
                    if (n == 0) begin
                        chk("noop_done_cycle", 32'(cyc), 32'(c + 1));
                        chk("noop_cmd_ready", 32'(cmd_ready), 32'd1);
                    end else chk("done_with_last", 32'(data_valid && data_last), 32'd1);
                end
            end
            if (cmd_valid && cmd_ready) begin
                model_cmd(cmd_addr, int'(cmd_words));
                exp_done.push_back(int'(cmd_words));
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Behavioural AXI responder and consumer backpressure
    initial begin
        burst_t rsp_q[$];
        int beat;
        logic ar_hs, r_hs;
        logic [31:0] ar_a;
        logic [7:0] ar_l;
        beat = 0;
        axi.s_arready = 1'b0;
        axi.s_rvalid = 1'b0;
        axi.s_rdata = '0;
        data_ready = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = axi.m_arvalid && axi.s_arready;
            ar_a = axi.m_araddr;
            ar_l = axi.m_arlen;
            r_hs = axi.s_rvalid && axi.m_rready;
            @(posedge clk);
            #1;
            if (reset) begin
                rsp_q.delete();
                beat = 0;
                axi.s_rvalid = 1'b0;
                axi.s_arready = 1'b0;
            end else begin
                if (r_hs) begin
                    beat++;
                    if (beat >= rsp_q[0].len) begin
                        void'(rsp_q.pop_front());
                        beat = 0;
                    end
                end
                if (ar_hs) rsp_q.push_back('{ar_a, int'(ar_l) + 1});
                axi.s_arready = ar_block > 0 ? 1'b0 : 1'($urandom_range(0, 1));
                if (ar_block > 0) ar_block--;
                if (!(axi.s_rvalid && !r_hs))
                    axi.s_rvalid = rsp_q.size() > 0 && $urandom_range(0, 4) != 0;
                axi.s_rdata = rsp_q.size() > 0 ? word_at(rsp_q[0].a + 32'(beat * 4)) : 32'd0;
            end
            data_ready = dr_low > 0 ? 1'b0 : $urandom_range(0, 3) != 0;
            if (dr_low > 0) dr_low--;
        end
    end

    task automatic send(input logic [31:0] a, input logic [15:0] w);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_words = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 2000);
        if (!cmd_ready) bad("cmd_accept_timeout");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_data();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_valid && n < 1000);
        if (!data_valid) bad("data_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || exp_ar.size() > 0 || exp_done.size() > 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) bad("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({nm, "_arvalid"}, 32'(axi.m_arvalid), 32'd0);
        chk({nm, "_rready"}, 32'(axi.m_rready), 32'd0);
        chk({nm, "_data_valid"}, 32'(data_valid), 32'd0);
        chk({nm, "_data_last"}, 32'(data_last), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_words = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_quiet("reset");
        chk("tie_offs", {29'd0, axi.m_awvalid, axi.m_wvalid, axi.m_bready}, 32'd1);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        send(32'h0000_1000, 16'd4);
        send(32'h0000_0000, 16'd20);
        send(32'h0000_0FF8, 16'd4);
        send(32'h0000_2000, 16'd16);
        wait_data();
        dr_low = 5;
        send(32'h0000_3000, 16'd0);
        drain();

        ar_block = 12;
        send(32'h0000_4000, 16'd40);
        wait_data();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_quiet("reset_mid_data");
        exp_q.delete();
        exp_ar.delete();
        exp_done.delete();
        acc_cyc.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        send(32'h0000_5000, 16'd8);
        send(32'hFFFF_FFF0, 16'd8);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a = {a[31:12], 12'hFC0 | 12'($urandom_range(0, 63))};
            send(a, 16'($urandom_range(0, 30)));
        end
        drain();
        chk("tie_offs_end", {29'd0, axi.m_awvalid, axi.m_wvalid, axi.m_bready}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
